// File: rtl/udma_tx_pkg.sv
// Shared types and width helpers for the uDMA TX prefetch buffer.
package udma_tx_pkg;

   // What happens to a read return in the cycle it arrives
   typedef enum logic [1:0] {
      RET_STORE,
      RET_DROP,
      RET_ERR
   } ret_act_e;

   // Counters must hold 0..depth inclusive
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   // Pointers index 0..depth-1, never narrower than one bit
   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 2) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/udma_tx_store.sv
// Storage array with wrapping read/write pointers and a fall-through head read.
module udma_tx_store
   import udma_tx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  clr_i,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  pop_i,
   input  logic                  head_valid_i,
   output logic [DATA_WIDTH-1:0] head_data_o
);

   localparam int unsigned       PTR_W    = ptr_width(DEPTH);
   localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q;
   logic [PTR_W-1:0]      wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q;
   logic [PTR_W-1:0]      rd_ptr_d;
   logic [DATA_WIDTH-1:0] hold_q;

   // Explicit wrap so non-power-of-two depths work
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (clr_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push_i && !clr_i) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   // Head is shown while valid; otherwise the last shown word is held
   assign head_data_o = head_valid_i ? mem_q[rd_ptr_q] : hold_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) hold_q <= '0;
      else         hold_q <= head_data_o;
   end

endmodule

// File: rtl/udma_tx_prefetch_fifo.sv
// TX prefetch buffer: credit-based read requests to the uDMA core, buffered
// in-order returns presented to a peripheral as a valid/ready stream.
module udma_tx_prefetch_fifo
   import udma_tx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned BUFFER_DEPTH = 4
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  clr_i,
   input  logic                  en_i,
   output logic                  req_o,
   input  logic                  gnt_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  valid_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic                  err_o
);

   localparam int unsigned       CNT_W   = cnt_width(BUFFER_DEPTH);
   localparam int unsigned       SUM_W   = CNT_W + 2;
   localparam logic [SUM_W-1:0]  DEPTH_S = SUM_W'(BUFFER_DEPTH);

   logic [CNT_W-1:0] stored_q;
   logic [CNT_W-1:0] stored_d;
   logic [CNT_W-1:0] inflight_q;
   logic [CNT_W-1:0] inflight_d;
   logic [CNT_W-1:0] drop_q;
   logic [CNT_W-1:0] drop_d;
   logic             err_q;
   logic             err_d;
   logic [SUM_W-1:0] occupancy;
   logic             grant;
   logic             pop;
   logic             ret_store;
   logic             ret_drop;
   logic             ret_err;
   ret_act_e         ret_act;

   // Every granted request already owns a slot, so returns never stall
   assign occupancy = SUM_W'(stored_q) + SUM_W'(inflight_q) + SUM_W'(drop_q);
   assign req_o     = en_i & ~clr_i & (occupancy < DEPTH_S);
   assign valid_o   = (stored_q != '0);
   assign err_o     = err_q;
   assign grant     = req_o & gnt_i;
   assign pop       = valid_o & ready_i;

   always_comb begin
      ret_act = RET_ERR;
      if (drop_q != '0)          ret_act = RET_DROP;
      else if (inflight_q != '0) ret_act = RET_STORE;
   end

   assign ret_store = valid_i & (ret_act == RET_STORE);
   assign ret_drop  = valid_i & (ret_act == RET_DROP);
   assign ret_err   = valid_i & (ret_act == RET_ERR);

   // Flush turns every outstanding return into a discard credit
   always_comb begin
      stored_d   = stored_q;
      inflight_d = inflight_q;
      drop_d     = drop_q;
      err_d      = err_q | ret_err;
      if (clr_i) begin
         stored_d   = '0;
         inflight_d = '0;
         drop_d     = inflight_q + drop_q - CNT_W'(ret_store | ret_drop);
      end else begin
         stored_d   = stored_q + CNT_W'(ret_store) - CNT_W'(pop);
         inflight_d = inflight_q + CNT_W'(grant) - CNT_W'(ret_store);
         drop_d     = drop_q - CNT_W'(ret_drop);
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         stored_q   <= '0;
         inflight_q <= '0;
         drop_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         stored_q   <= stored_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
         err_q      <= err_d;
      end
   end

   udma_tx_store #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (BUFFER_DEPTH)
   ) u_store (
      .clk_i        (clk_i),
      .rstn_i       (rstn_i),
      .clr_i        (clr_i),
      .push_i       (ret_store),
      .push_data_i  (data_i),
      .pop_i        (pop),
      .head_valid_i (valid_o),
      .head_data_o  (data_o)
   );

endmodule

// File: tb/tb_udma_tx_prefetch_fifo.sv
// Directed bench for udma_tx_prefetch_fifo (depth 4 main instance, depth 3 wrap instance).
module tb_udma_tx_prefetch_fifo;

   localparam int unsigned DW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rstn, clr, en, gnt, vin, rdy;
   logic [DW-1:0] din;
   logic          req, vout, err;
   logic [DW-1:0] dout;

   logic          d3_rstn, d3_clr, d3_en, d3_gnt, d3_vin, d3_rdy;
   logic [DW-1:0] d3_din;
   logic          d3_req, d3_vout, d3_err;
   logic [DW-1:0] d3_dout;

   udma_tx_prefetch_fifo #(.DATA_WIDTH(DW), .BUFFER_DEPTH(4)) u_dut (
      .clk_i(clk), .rstn_i(rstn), .clr_i(clr), .en_i(en), .req_o(req), .gnt_i(gnt),
      .data_i(din), .valid_i(vin), .data_o(dout), .valid_o(vout), .ready_i(rdy), .err_o(err)
   );

   udma_tx_prefetch_fifo #(.DATA_WIDTH(DW), .BUFFER_DEPTH(3)) u_d3 (
      .clk_i(clk), .rstn_i(d3_rstn), .clr_i(d3_clr), .en_i(d3_en), .req_o(d3_req), .gnt_i(d3_gnt),
      .data_i(d3_din), .valid_i(d3_vin), .data_o(d3_dout), .valid_o(d3_vout), .ready_i(d3_rdy),
      .err_o(d3_err)
   );

   typedef struct packed {
      logic          en, clr, gnt, vin;
      logic [DW-1:0] din;
      logic          rdy;
      logic          req, vout;
      logic [DW-1:0] dout;
      logic          err;
   } vec_t;

   vec_t          tv [12];
   int            total = 0;
   int            bad   = 0;
   int            cycle, ret_dly, limit, grants;
   int            pend_due [$];
   logic [DW-1:0] pend_dat [$];
   logic [DW-1:0] got [$];
   logic [DW-1:0] next_word;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      rstn = 1'b0; en = 1'b0; clr = 1'b0; gnt = 1'b0; vin = 1'b0; din = '0; rdy = 1'b0;
      pend_due.delete(); pend_dat.delete(); got.delete();
      grants = 0; limit = 0; ret_dly = 1; cycle = 0;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
   endtask

   // One cycle of the memory-side responder plus stream sink
   task automatic step();
      if (pend_due.size() > 0 && pend_due[0] <= cycle) begin
         vin = 1'b1;
         din = pend_dat.pop_front();
         void'(pend_due.pop_front());
      end else begin
         vin = 1'b0;
         din = '0;
      end
      gnt = (grants < limit);
      #1;
      if (req && gnt) begin
         pend_due.push_back(cycle + ret_dly);
         pend_dat.push_back(next_word);
         next_word = next_word + DW'(1);
         grants++;
      end
      if (vout && rdy) got.push_back(dout);
      @(posedge clk);
      #1;
      cycle++;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      d3_rstn = 1'b0; d3_clr = 1'b0; d3_en = 1'b0; d3_gnt = 1'b0;
      d3_vin = 1'b0; d3_din = '0; d3_rdy = 1'b0;

      //               en   clr  gnt  vin  din       rdy  req  vout dout      err
      tv[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0};
      tv[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'hA1, 1'b0, 1'b1, 1'b1, 32'hA1, 1'b0};
      tv[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'hA2, 1'b1, 1'b1, 1'b1, 32'hA2, 1'b0};
      tv[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'hA2, 1'b0};
      tv[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 32'hA2, 1'b1};
      tv[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'hA2, 1'b1};
      tv[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 32'hA2, 1'b1};
      tv[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h66, 1'b0, 1'b0, 1'b0, 32'hA2, 1'b1};
      tv[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 32'hA2, 1'b1};
      tv[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'hA2, 1'b1};
      tv[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h77, 1'b0, 1'b1, 1'b0, 32'hA2, 1'b1};
      tv[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h88, 1'b0, 1'b1, 1'b1, 32'h88, 1'b1};

      // Reset values
      do_reset();
      chk("rst_req", DW'(req), 0);
      chk("rst_valid", DW'(vout), 0);
      chk("rst_data", dout, 0);
      chk("rst_err", DW'(err), 0);

      // Cycle-by-cycle vectors: req sampled before the edge, outputs after it
      for (int i = 0; i < 12; i++) begin
         en = tv[i].en; clr = tv[i].clr; gnt = tv[i].gnt;
         vin = tv[i].vin; din = tv[i].din; rdy = tv[i].rdy;
         #1;
         chk($sformatf("tv%0d_req", i), DW'(req), DW'(tv[i].req));
         @(posedge clk);
         #1;
         chk($sformatf("tv%0d_valid", i), DW'(vout), DW'(tv[i].vout));
         chk($sformatf("tv%0d_data", i), dout, tv[i].dout);
         chk($sformatf("tv%0d_err", i), DW'(err), DW'(tv[i].err));
      end

      // Streaming 1..8 with 1-cycle returns
      do_reset();
      en = 1'b1; rdy = 1'b1; ret_dly = 1; limit = 8; next_word = 32'h1;
      for (int k = 0; k < 40 && got.size() < 8; k++) step();
      chk("stream_cnt", DW'(got.size()), 8);
      if (got.size() == 8)
         for (int i = 0; i < 8; i++) chk($sformatf("stream_w%0d", i), got[i], DW'(i + 1));
      chk("stream_err", DW'(err), 0);

      // Credit limit with a stalled sink
      do_reset();
      en = 1'b1; rdy = 1'b0; ret_dly = 1; limit = 100; next_word = 32'h20;
      repeat (10) step();
      chk("full_grants", DW'(grants), 4);
      chk("full_req", DW'(req), 0);
      chk("full_valid", DW'(vout), 1);
      chk("full_head", dout, 32'h20);
      rdy = 1'b1;
      step();
      rdy = 1'b0;
      chk("pop_req", DW'(req), 1);
      limit = 5; rdy = 1'b1;
      repeat (20) step();
      chk("full_cnt", DW'(got.size()), 5);
      if (got.size() == 5)
         for (int i = 0; i < 5; i++) chk($sformatf("full_w%0d", i), got[i], DW'(32'h20 + i));

      // Return and pop in the same cycle at stored = depth-1
      do_reset();
      en = 1'b1; rdy = 1'b0; ret_dly = 1; limit = 3; next_word = 32'h1;
      repeat (6) step();
      chk("rp_pre_head", dout, 32'h1);
      limit = 4;
      step();
      rdy = 1'b1;
      step();
      rdy = 1'b0;
      chk("rp_valid", DW'(vout), 1);
      chk("rp_head", dout, 32'h2);
      rdy = 1'b1;
      repeat (10) step();
      chk("rp_cnt", DW'(got.size()), 4);
      if (got.size() == 4)
         for (int i = 0; i < 4; i++) chk($sformatf("rp_w%0d", i), got[i], DW'(i + 1));
      chk("rp_empty", DW'(vout), 0);

      // Flush with three slow returns outstanding
      do_reset();
      en = 1'b1; rdy = 1'b1; ret_dly = 4; limit = 3; next_word = 32'h11;
      repeat (3) step();
      chk("clr_grants", DW'(grants), 3);
      clr = 1'b1; limit = 4; next_word = 32'hA5;
      step();
      clr = 1'b0;
      chk("clr_valid", DW'(vout), 0);
      repeat (20) step();
      chk("clr_cnt", DW'(got.size()), 1);
      if (got.size() == 1) chk("clr_word", got[0], 32'hA5);
      chk("clr_err", DW'(err), 0);

      // Unsolicited return
      do_reset();
      pend_due.push_back(cycle);
      pend_dat.push_back(32'h77);
      step();
      chk("unsol_err", DW'(err), 1);
      chk("unsol_valid", DW'(vout), 0);
      repeat (3) step();
      chk("unsol_sticky", DW'(err), 1);

      // Depth 3: pointer wrap with random back-pressure and return delay
      begin
         int            g3, p3, cyc3, last_due, due;
         int            q3_due [$];
         logic [DW-1:0] q3_dat [$];
         g3 = 0; p3 = 0; cyc3 = 0; last_due = 0;
         @(posedge clk);
         #1 d3_rstn = 1'b1;
         d3_en = 1'b1;
         for (int k = 0; k < 400 && p3 < 10; k++) begin
            if (q3_due.size() > 0 && q3_due[0] <= cyc3) begin
               d3_vin = 1'b1;
               d3_din = q3_dat.pop_front();
               void'(q3_due.pop_front());
            end else begin
               d3_vin = 1'b0;
               d3_din = '0;
            end
            d3_rdy = 1'($urandom_range(0, 1));
            d3_gnt = (g3 < 10);
            #1;
            if (g3 - p3 >= 3) chk("d3_req_full", DW'(d3_req), 0);
            if (d3_req && d3_gnt) begin
               due = cyc3 + int'($urandom_range(1, 3));
               if (due <= last_due) due = last_due + 1;
               last_due = due;
               q3_due.push_back(due);
               q3_dat.push_back(DW'(32'h10 + g3));
               g3++;
            end
            if (d3_vout && d3_rdy) begin
               chk($sformatf("d3_w%0d", p3), d3_dout, DW'(32'h10 + p3));
               p3++;
            end
            @(posedge clk);
            #1;
            cyc3++;
         end
         chk("d3_cnt", DW'(p3), 10);
         chk("d3_err", DW'(d3_err), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/udma_tx_prefetch_fifo.md
Name: udma_tx_prefetch_fifo

Overview:
- Single-clock TX-side buffer for the uDMA.
- Issues read requests to the uDMA core with a req/gnt handshake and accepts the returned read data in order.
- Buffers that data and presents it to a peripheral transmitter as a valid/ready stream.
- A credit counter guarantees that every granted request has a reserved slot, so returned data is never back-pressured.

Parameters:
DATA_WIDTH, 32, width of data word
BUFFER_DEPTH, 4, number of storage entries (>=2; any integer)

Ports:
clk_i  input  1  clock
rstn_i  input  1  asynchronous active-low reset
clr_i  input  1  synchronous flush of buffer and pending returns
en_i  input  1  enables request issue
req_o  output  1  read request to uDMA core
gnt_i  input  1  request accepted this cycle (valid only with req_o)
data_i  input  DATA_WIDTH  returned read data
valid_i  input  1  data_i valid (in order, >=1 cycle after its grant)
data_o  output  DATA_WIDTH  head-of-buffer data to peripheral
valid_o  output  1  buffer non-empty
ready_i  input  1  peripheral consumes head
err_o  output  1  sticky: valid_i arrived with no outstanding request

Behaviour:
- Clock and reset: one clock (clk_i); reset is asynchronous and active-low (rstn_i).
- Reset values: req_o=0, valid_o=0, data_o=0, err_o=0. All pointers and counters are 0.
- Counters, each $clog2(BUFFER_DEPTH+1) bits:
  - stored: valid entries in the buffer.
  - inflight: granted but not yet returned.
  - drop: returns to discard after a flush.
- Request rule: req_o = en_i & !clr_i & (stored + inflight + drop < BUFFER_DEPTH). It is combinational from registered counters plus en_i/clr_i.
- Grant: if req_o & gnt_i, inflight is incremented at the next edge.
- Return while drop>0: data is discarded and drop is decremented.
- Return while drop==0 and inflight>0: data_i is written at wr_ptr, wr_ptr advances, stored increments, inflight decrements.
- Return with inflight==0 and drop==0: data is discarded and err_o is set (sticky until reset).
- Output: fall-through. valid_o = (stored != 0); data_o = mem[rd_ptr] when valid_o, otherwise the last registered value (X not allowed; it holds).
- Pop: on valid_o & ready_i, rd_ptr advances and stored decrements.
- Simultaneity: the grant, return and pop of one cycle all apply at the same edge; the counter nets are computed together (e.g. return+pop leaves stored unchanged).
- Overflow is impossible by construction: push at stored==BUFFER_DEPTH cannot happen.
- Latency: returned data is visible on data_o/valid_o the cycle after valid_i. Minimum req->data_o latency is 2 cycles with a 1-cycle return.
- Pointer wrap: pointers are $clog2(BUFFER_DEPTH) bits and wrap explicitly from BUFFER_DEPTH-1 to 0, so non-power-of-two depths are legal.
- clr_i (priority over everything except reset):
  - At the edge: stored=0, rd_ptr=wr_ptr=0.
  - drop is set to inflight + drop, including a return arriving in the clear cycle, which is discarded, and excluding any grant in the clear cycle (req_o=0, so none).
  - inflight=0. err_o is unaffected.
  - Requests resume the cycle after clr_i deasserts, bounded by the drop credit.
- en_i low: blocks new requests only. Outstanding returns and pops continue.
- Reset mid-operation: everything returns to reset values immediately. Returns after reset are treated as unsolicited (err_o); the integrator must reset both sides together.

Decomposition:
- Package udma_tx_pkg holds:
  - The counter-width function/localparam derivation (CNT_W = $clog2(BUFFER_DEPTH+1), PTR_W = max(1,$clog2(BUFFER_DEPTH))).
  - A typedef for the return-handling action enum: RET_STORE, RET_DROP, RET_ERR.
- One sub-module, udma_tx_store, is natural: the storage array with wr/rd pointers, wrap logic and fall-through read.
- The credit/drop accounting and request generation stay in the top level.

Test Plan:
- Reset then en_i=1, gnt_i=1 every cycle, returns 1 cycle later with data 0x1..0x8, ready_i=1 -> data_o sequence 0x1..0x8 in order, err_o=0.
- ready_i=0, BUFFER_DEPTH=4, gnt always -> exactly 4 grants and req_o=0 thereafter. After 4 returns stored=4. One pop re-asserts req_o the next cycle.
- Return delay 3 cycles, 3 grants outstanding, pulse clr_i -> valid_o=0 next cycle, 3 subsequent returns dropped, the next return (0xA5) appears on data_o, err_o=0.
- valid_i pulse with nothing outstanding after reset -> err_o=1 and stays 1; valid_o stays 0.
- BUFFER_DEPTH=3, 10 words 0x10..0x19 with random ready_i -> all 10 words are delivered in order across pointer wrap; req_o is never asserted when stored+inflight=3.
- Same-cycle return and pop at stored=BUFFER_DEPTH-1 -> stored unchanged, data ordering preserved.
